// File: rtl/moore_pattern_detector.sv
// Moore serial pattern detector with a runtime pattern, optional overlap and a
// saturating hit counter; z and HitCount come straight from registers.
module moore_pattern_detector #(
    parameter int PAT_LEN = 3,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               w,
    input  logic [PAT_LEN-1:0] Pattern,
    input  logic               Clear,
    output logic               z,
    output logic [CNT_W-1:0]   HitCount
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FULL    = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
    logic [FW-1:0]      fill_q, fill_d, fill_n;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        hist_n = {hist_q[PAT_LEN-2:0], w};
        fill_n = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
        hit    = Enable && (fill_n == FULL) && (hist_n == Pattern);
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = hit;
        if (Enable) begin
            hist_d = hist_n;
            // Non-overlap mode starts a fresh window after every match.
            fill_d = (hit && (OVERLAP == 0)) ? '0 : fill_n;
        end
        cnt_d = cnt_q;
        if (Clear)
            cnt_d = '0;
        else if (hit && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        z        = z_q;
        HitCount = cnt_q;
    end
endmodule

// File: tb/tb_moore_pattern_detector.sv
// Bench for moore_pattern_detector: three configurations share one stimulus
// stream; a reference model queues expected outputs per driven cycle.
module tb_moore_pattern_detector;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1, Enable = 1'b0, w = 1'b0, Clear = 1'b0;
    logic [2:0] Pattern = 3'b111;
    logic       z_ov, z_nv, z_st;
    logic [7:0] hc_ov, hc_nv;
    logic [1:0] hc_st;

    always #5 Clock = ~Clock;

    moore_pattern_detector #(.PAT_LEN(3), .OVERLAP(1), .CNT_W(8)) u_ov (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .w(w), .Pattern(Pattern),
        .Clear(Clear), .z(z_ov), .HitCount(hc_ov));
    moore_pattern_detector #(.PAT_LEN(3), .OVERLAP(0), .CNT_W(8)) u_nv (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .w(w), .Pattern(Pattern),
        .Clear(Clear), .z(z_nv), .HitCount(hc_nv));
    moore_pattern_detector #(.PAT_LEN(3), .OVERLAP(1), .CNT_W(2)) u_st (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .w(w), .Pattern(Pattern),
        .Clear(Clear), .z(z_st), .HitCount(hc_st));

    typedef struct {
        logic z0, z1, z2;
        int   c0, c1, c2;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;

    // reference model state: index 0 overlap, 1 non-overlap, 2 two-bit counter
    logic [2:0] m_hist[3];
    int         m_fill[3];
    int         m_cnt[3];
    logic       m_z[3];
    int         m_max[3] = '{255, 255, 3};
    int         m_ovl[3] = '{1, 0, 1};

    task automatic step(input logic rst, input logic en, input logic wi, input logic clr);
        exp_t e;
        logic hit;
        Reset = rst; Enable = en; w = wi; Clear = clr;
        for (int c = 0; c < 3; c++) begin
            hit = 1'b0;
            if (rst) begin
                m_hist[c] = 3'b000; m_fill[c] = 0; m_z[c] = 1'b0; m_cnt[c] = 0;
            end else begin
                if (en) begin
                    m_hist[c] = {m_hist[c][1:0], wi};
                    if (m_fill[c] < 3) m_fill[c]++;
                    hit = (m_fill[c] == 3) && (m_hist[c] == Pattern);
                    if (hit && m_ovl[c] == 0) m_fill[c] = 0;
                end
                m_z[c] = hit;
                if (clr) m_cnt[c] = 0;
                else if (hit && m_cnt[c] < m_max[c]) m_cnt[c]++;
            end
        end
        e.z0 = m_z[0]; e.z1 = m_z[1]; e.z2 = m_z[2];
        e.c0 = m_cnt[0]; e.c1 = m_cnt[1]; e.c2 = m_cnt[2];
        sb.push_back(e);
        @(posedge Clock);
        #1;
        e = sb.pop_front();
        total++;
        if (z_ov !== e.z0 || int'(hc_ov) !== e.c0) begin
            bad++;
            $display("FAIL sb_ovl t=%0t got z=%b hc=%0d want z=%b hc=%0d", $time, z_ov, hc_ov, e.z0, e.c0);
        end
        total++;
        if (z_nv !== e.z1 || int'(hc_nv) !== e.c1) begin
            bad++;
            $display("FAIL sb_novl t=%0t got z=%b hc=%0d want z=%b hc=%0d", $time, z_nv, hc_nv, e.z1, e.c1);
        end
        total++;
        if (z_st !== e.z2 || int'(hc_st) !== e.c2) begin
            bad++;
            $display("FAIL sb_sat t=%0t got z=%b hc=%0d want z=%b hc=%0d", $time, z_st, hc_st, e.z2, e.c2);
        end
    endtask

    task automatic test_reset;
        Pattern = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            total++;
            if ({z_ov, z_nv, z_st} !== 3'b000 || hc_ov !== 8'd0 || hc_nv !== 8'd0 || hc_st !== 2'd0) begin
                bad++;
                $display("FAIL reset_hold got z=%b%b%b hc=%0d/%0d/%0d want all 0", z_ov, z_nv, z_st, hc_ov, hc_nv, hc_st);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            total++;
            if ({z_ov, z_nv, z_st} !== 3'b000) begin
                bad++;
                $display("FAIL reset_early_hit sample=%0d got z=%b%b%b want 000", i + 1, z_ov, z_nv, z_st);
            end
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if ({z_ov, z_nv, z_st} !== 3'b111) begin
            bad++;
            $display("FAIL reset_first_hit got z=%b%b%b want 111", z_ov, z_nv, z_st);
        end
    endtask

    task automatic test_overlap_modes;
        logic [4:0] zo, zn;
        Pattern = 3'b111;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            zo[4-i] = z_ov;
            zn[4-i] = z_nv;
        end
        total++;
        if (zo !== 5'b00111 || hc_ov !== 8'd3) begin
            bad++;
            $display("FAIL overlap_run got z=%b hc=%0d want z=00111 hc=3", zo, hc_ov);
        end
        total++;
        if (zn !== 5'b00100 || hc_nv !== 8'd1) begin
            bad++;
            $display("FAIL nonoverlap_run got z=%b hc=%0d want z=00100 hc=1", zn, hc_nv);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (z_nv !== 1'b1 || hc_nv !== 8'd2) begin
            bad++;
            $display("FAIL nonoverlap_second got z=%b hc=%0d want z=1 hc=2", z_nv, hc_nv);
        end
    endtask

    task automatic test_pattern_enable;
        Pattern = 3'b101;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            total++;
            if ({z_ov, z_nv, z_st} !== 3'b000) begin
                bad++;
                $display("FAIL enable_hold got z=%b%b%b want 000", z_ov, z_nv, z_st);
            end
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if ({z_ov, z_nv, z_st} !== 3'b111 || hc_ov !== 8'd1 || hc_st !== 2'd1) begin
            bad++;
            $display("FAIL pattern_101 got z=%b%b%b hc=%0d/%0d want z=111 hc=1/1", z_ov, z_nv, z_st, hc_ov, hc_st);
        end
    endtask

    task automatic test_sat_clear;
        Pattern = 3'b111;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (hc_st !== 2'd3 || hc_ov !== 8'd6) begin
            bad++;
            $display("FAIL saturate got hc_sat=%0d hc_ovl=%0d want 3 and 6", hc_st, hc_ov);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        if (z_st !== 1'b1 || hc_st !== 2'd0 || hc_ov !== 8'd0) begin
            bad++;
            $display("FAIL clear_on_hit got z=%b hc=%0d/%0d want z=1 hc=0/0", z_st, hc_st, hc_ov);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (hc_st !== 2'd1) begin
            bad++;
            $display("FAIL after_clear got hc=%0d want 1", hc_st);
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] zs;
        Pattern = 3'b111;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            zs[2-i] = z_ov;
        end
        total++;
        if (zs !== 3'b001) begin
            bad++;
            $display("FAIL reset_mid got z seq=%b want 001", zs);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) Pattern = 3'($urandom_range(0, 7));
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_hist[c] = 3'b000; m_fill[c] = 0; m_cnt[c] = 0; m_z[c] = 1'b0;
        end
        #1;
        test_reset;
        test_overlap_modes;
        test_pattern_enable;
        test_sat_clear;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
